// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// A wb_entry bundles one long-unit result with its destination register.
package regfile_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO that buffers long-unit results until a free write slot appears.
// The head is read combinationally so the arbiter can commit it in the same cycle.
module wb_result_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [REG_ADDR_W-1:0]    push_rd_i,
    input  logic [XLEN-1:0]          push_data_i,
    input  logic                     pop_i,
    output logic [REG_ADDR_W-1:0]    head_rd_o,
    output logic [XLEN-1:0]          head_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;
    wb_entry_t       head_entry;

    assign full_o  = (count_q == CNT_DEPTH);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_entry  = mem_q[rd_ptr_q];
    assign head_rd_o   = head_entry.rd;
    assign head_data_o = head_entry.data;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= '{rd: push_rd_i, data: push_data_i};
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered long-unit results, with a starvation guard and a pending scoreboard.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_wr_en,
    input  logic [REG_ADDR_W-1:0]  pipe_wr_addr,
    input  logic [XLEN-1:0]        pipe_wr_data,
    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [REG_ADDR_W-1:0]  lu_rd,
    input  logic [XLEN-1:0]        lu_data,
    input  logic                   issue_valid,
    input  logic [REG_ADDR_W-1:0]  issue_rd,
    input  logic [REG_ADDR_W-1:0]  rs1_addr,
    input  logic [REG_ADDR_W-1:0]  rs2_addr,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    output logic                   rf_wr_en,
    output logic [REG_ADDR_W-1:0]  rf_wr_addr,
    output logic [XLEN-1:0]        rf_wr_data,
    output logic                   pipe_stall
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]  CNT_FULL    = CW'(FIFO_DEPTH);
    localparam logic [SCW-1:0] STARVE_LAST = SCW'(STARVE_LIMIT - 1);
    localparam logic [SCW-1:0] STARVE_ONE  = SCW'(1);

    logic                   fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic [REG_ADDR_W-1:0]  head_rd;
    logic [XLEN-1:0]        head_data;
    logic                   pipe_use, commit, blocked, issue_set;
    logic [SCW-1:0]         starve_q, starve_d;
    logic                   stall_q, stall_d;
    logic [NUM_REGS-1:0]    pending_q, pending_d;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_rd_i   (lu_rd),
        .push_data_i (lu_data),
        .pop_i       (commit),
        .head_rd_o   (head_rd),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Results for x0 are handshaken but never stored, so the head rd is never 0.
    assign lu_ready  = !rst && (fifo_count != CNT_FULL);
    assign fifo_push = lu_valid && lu_ready && !fifo_full && (lu_rd != '0);

    assign pipe_use = pipe_wr_en && (pipe_wr_addr != '0) && !stall_q;
    assign commit   = !rst && !pipe_use && !fifo_empty;
    assign blocked  = !fifo_empty && !commit;

    always_comb begin
        rf_wr_en   = 1'b0;
        rf_wr_addr = '0;
        rf_wr_data = '0;
        if (!rst && pipe_use) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = pipe_wr_addr;
            rf_wr_data = pipe_wr_data;
        end else if (commit) begin
            rf_wr_en   = 1'b1;
            rf_wr_addr = head_rd;
            rf_wr_data = head_data;
        end
    end

    // The stall forces a commit, so the counter never runs past STARVE_LIMIT.
    always_comb begin
        starve_d = blocked ? starve_q + STARVE_ONE : '0;
        stall_d  = blocked && (starve_q == STARVE_LAST);
    end

    assign issue_set = issue_valid && (issue_rd != '0);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
        localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(gi);
        // A new issue to the same register outranks the commit clearing it.
        assign pending_d[gi] = (issue_set && (issue_rd == IDX))
                             || (pending_q[gi] && !(commit && (head_rd == IDX)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q  <= '0;
            stall_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            pending_q <= pending_d;
        end
    end

    assign pipe_stall = stall_q;
    assign rs1_busy   = pending_q[rs1_addr] && (rs1_addr != '0);
    assign rs2_busy   = pending_q[rs2_addr] && (rs2_addr != '0);

endmodule
